// File: rtl/core_pkg.sv
// Shared core types: CDB bundle as seen by reservation stations and the ROB.
package core_pkg;

    localparam int unsigned TAG_W  = 6;
    localparam int unsigned DATA_W = 32;

    typedef struct packed {
        logic              valid;
        logic [TAG_W-1:0]  tag;
        logic [DATA_W-1:0] data;
    } cdb_t;

endpackage

// File: rtl/cdb_broadcaster_rr_arbiter.sv
// Combinational round-robin arbiter: first requester at or after ptr wins.
module rr_arbiter #(
    parameter int unsigned N     = 4,
    parameter int unsigned IDX_W = 2
) (
    input  logic [N-1:0]     req,
    input  logic [IDX_W-1:0] ptr,
    output logic [N-1:0]     grant,
    output logic [IDX_W-1:0] grant_idx
);

    // Index ptr+off folded back into 0..N-1 (off < N, so one subtraction suffices).
    function automatic int unsigned wrap_idx(input int unsigned base, input int unsigned off);
        int unsigned s;
        s = base + off;
        return (s >= N) ? (s - N) : s;
    endfunction

    logic w_found;

    // Scan from the pointer and stop at the first asserted request.
    always_comb begin
        grant     = '0;
        grant_idx = '0;
        w_found   = 1'b0;
        for (int unsigned k = 0; k < N; k++) begin
            if (!w_found && req[wrap_idx(int'(ptr), k)]) begin
                grant[wrap_idx(int'(ptr), k)] = 1'b1;
                grant_idx                     = IDX_W'(wrap_idx(int'(ptr), k));
                w_found                       = 1'b1;
            end
        end
    end

endmodule

// File: rtl/cdb_broadcaster.sv
// CDB producer: round-robin selects one completed FU result per cycle and
// drives it, registered, onto the common data bus.
module cdb_broadcaster #(
    parameter int unsigned NUM_SRC = 4,
    parameter int unsigned TAG_W   = 6,
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned SRC_W   = 2
) (
    input  logic                        clk,
    input  logic                        reset_n,
    input  logic                        flush,
    input  logic [NUM_SRC-1:0]          src_valid,
    input  logic [NUM_SRC*TAG_W-1:0]    src_tag,
    input  logic [NUM_SRC*DATA_W-1:0]   src_data,
    output logic [NUM_SRC-1:0]          src_ready,
    output logic                        cdb_valid,
    output logic [TAG_W-1:0]            cdb_tag,
    output logic [DATA_W-1:0]           cdb_data,
    output logic [SRC_W-1:0]            cdb_src
);

    import core_pkg::*;

    logic [NUM_SRC-1:0] w_grant;
    logic [SRC_W-1:0]   w_grant_idx;
    logic [SRC_W-1:0]   w_next_ptr;
    logic               w_accept;
    logic [TAG_W-1:0]   w_sel_tag;
    logic [DATA_W-1:0]  w_sel_data;

    cdb_t               r_cdb;
    logic [SRC_W-1:0]   r_cdb_src;
    logic [SRC_W-1:0]   r_rr_ptr;

    rr_arbiter #(
        .N     (NUM_SRC),
        .IDX_W (SRC_W)
    ) u_arb (
        .req       (src_valid),
        .ptr       (r_rr_ptr),
        .grant     (w_grant),
        .grant_idx (w_grant_idx)
    );

    // A result is taken only when out of reset, not flushing, and someone is valid.
    assign w_accept   = reset_n & ~flush & (|src_valid);
    assign src_ready  = w_accept ? w_grant : '0;

    assign w_sel_tag  = src_tag[w_grant_idx*TAG_W +: TAG_W];
    assign w_sel_data = src_data[w_grant_idx*DATA_W +: DATA_W];

    // Pointer moves one past the winner so it has lowest priority next time.
    assign w_next_ptr = (w_grant_idx == SRC_W'(NUM_SRC - 1)) ? '0 : (w_grant_idx + SRC_W'(1));

    // Broadcast register and round-robin pointer; payload holds when idle.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_cdb     <= '0;
            r_cdb_src <= '0;
            r_rr_ptr  <= '0;
        end else if (w_accept) begin
            r_cdb.valid <= 1'b1;
            r_cdb.tag   <= w_sel_tag;
            r_cdb.data  <= w_sel_data;
            r_cdb_src   <= w_grant_idx;
            r_rr_ptr    <= w_next_ptr;
        end else begin
            r_cdb.valid <= 1'b0;
        end
    end

    assign cdb_valid = r_cdb.valid;
    assign cdb_tag   = r_cdb.tag;
    assign cdb_data  = r_cdb.data;
    assign cdb_src   = r_cdb_src;

endmodule

// File: tb/tb_cdb_broadcaster.sv
// Self-checking bench for cdb_broadcaster against a behavioural CDB model.
module tb_cdb_broadcaster;

    localparam int NS = 4;
    localparam int TW = 6;
    localparam int DW = 32;
    localparam int SW = 2;

    logic              clk = 1'b0;
    logic              reset_n;
    logic              flush;
    logic [NS-1:0]     src_valid;
    logic [NS*TW-1:0]  src_tag;
    logic [NS*DW-1:0]  src_data;
    logic [NS-1:0]     src_ready;
    logic              cdb_valid;
    logic [TW-1:0]     cdb_tag;
    logic [DW-1:0]     cdb_data;
    logic [SW-1:0]     cdb_src;

    always #5 clk = ~clk;

    cdb_broadcaster #(
        .NUM_SRC (NS),
        .TAG_W   (TW),
        .DATA_W  (DW),
        .SRC_W   (SW)
    ) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .flush     (flush),
        .src_valid (src_valid),
        .src_tag   (src_tag),
        .src_data  (src_data),
        .src_ready (src_ready),
        .cdb_valid (cdb_valid),
        .cdb_tag   (cdb_tag),
        .cdb_data  (cdb_data),
        .cdb_src   (cdb_src)
    );

    int errors = 0;
    int checks = 0;

    logic [TW-1:0] t_tag  [NS];
    logic [DW-1:0] t_data [NS];

    // Reference model state: what the bus should show and where priority starts.
    int            m_ptr;
    logic          m_valid;
    logic [TW-1:0] m_tag;
    logic [DW-1:0] m_data;
    int            m_src;
    logic [NS-1:0] exp_r;

    // First valid source in circular order starting at ptr, -1 if none.
    function automatic int model_winner(input logic [NS-1:0] v, input int ptr);
        for (int k = 0; k < NS; k++) begin
            if (v[(ptr + k) % NS]) return (ptr + k) % NS;
        end
        return -1;
    endfunction

    function automatic logic [NS-1:0] model_ready();
        int w;
        if (!reset_n || flush) return '0;
        w = model_winner(src_valid, m_ptr);
        if (w < 0) return '0;
        return NS'(1) << w;
    endfunction

    task automatic drive(input logic rn, input logic fl, input logic [NS-1:0] v);
        @(negedge clk);
        reset_n   = rn;
        flush     = fl;
        src_valid = v;
        for (int i = 0; i < NS; i++) begin
            src_tag[i*TW +: TW]  = t_tag[i];
            src_data[i*DW +: DW] = t_data[i];
        end
        #1;
    endtask

    // Advance one clock and apply the spec's update rules to the model.
    task automatic tick();
        int w;
        @(posedge clk);
        if (!reset_n) begin
            m_valid = 1'b0; m_tag = '0; m_data = '0; m_src = 0; m_ptr = 0;
        end else begin
            w = model_winner(src_valid, m_ptr);
            if (flush || w < 0) begin
                m_valid = 1'b0;
            end else begin
                m_valid = 1'b1;
                m_tag   = t_tag[w];
                m_data  = t_data[w];
                m_src   = w;
                m_ptr   = (w + 1) % NS;
            end
        end
        #1;
    endtask

    task automatic test_reset();
        for (int c = 0; c < 2; c++) begin
            drive(1'b0, 1'b0, 4'b1111);
            checks++;
            if (src_ready !== 4'b0000) begin
                errors++; $display("FAIL reset_ready got=%b exp=0000", src_ready);
            end
            tick();
            checks++;
            if ({cdb_valid, cdb_tag, cdb_data, cdb_src} !== {1'b0, TW'(0), DW'(0), SW'(0)}) begin
                errors++; $display("FAIL reset_cdb got=%b/%h/%h/%0d exp=0/0/0/0", cdb_valid, cdb_tag, cdb_data, cdb_src);
            end
        end
        drive(1'b1, 1'b0, 4'b1111);
        checks++;
        if (src_ready !== 4'b0001) begin
            errors++; $display("FAIL reset_first_grant got=%b exp=0001", src_ready);
        end
        tick();
        checks++;
        if ({cdb_valid, cdb_tag, cdb_data, cdb_src} !== {1'b1, m_tag, m_data, SW'(0)}) begin
            errors++; $display("FAIL reset_first_bcast got=%b/%h/%h/%0d exp=1/%h/%h/0", cdb_valid, cdb_tag, cdb_data, cdb_src, m_tag, m_data);
        end
    endtask

    task automatic test_single();
        t_tag[2] = 6'h2A; t_data[2] = 32'hDEADBEEF;
        drive(1'b1, 1'b0, 4'b0100);
        checks++;
        if (src_ready !== 4'b0100) begin
            errors++; $display("FAIL single_ready got=%b exp=0100", src_ready);
        end
        tick();
        checks++;
        if ({cdb_valid, cdb_tag, cdb_data, cdb_src} !== {1'b1, 6'h2A, 32'hDEADBEEF, 2'd2}) begin
            errors++; $display("FAIL single_bcast got=%b/%h/%h/%0d exp=1/2a/deadbeef/2", cdb_valid, cdb_tag, cdb_data, cdb_src);
        end
        drive(1'b1, 1'b0, 4'b0000);
        checks++;
        if (src_ready !== 4'b0000) begin
            errors++; $display("FAIL single_idle_ready got=%b exp=0000", src_ready);
        end
        tick();
        checks++;
        if ({cdb_valid, cdb_tag, cdb_data, cdb_src} !== {1'b0, 6'h2A, 32'hDEADBEEF, 2'd2}) begin
            errors++; $display("FAIL single_idle_cdb got=%b/%h/%h/%0d exp=0/2a/deadbeef/2", cdb_valid, cdb_tag, cdb_data, cdb_src);
        end
    endtask

    // Pointer is 3 after the single-source test; sparse requests must skip absent sources.
    task automatic test_wrap_sparse();
        logic [NS-1:0] pat [2];
        pat[0] = 4'b0011; pat[1] = 4'b0001;
        t_tag[0] = 6'h00; t_data[0] = 32'h0000_0A0A;
        t_tag[1] = 6'h3F; t_data[1] = 32'hFFFF_0001;
        for (int c = 0; c < 2; c++) begin
            drive(1'b1, 1'b0, pat[c]);
            exp_r = model_ready();
            checks++;
            if (src_ready !== exp_r || src_ready !== 4'b0001) begin
                errors++; $display("FAIL wrap_ready[%0d] got=%b exp=%b", c, src_ready, exp_r);
            end
            tick();
            checks++;
            if ({cdb_valid, cdb_tag, cdb_data, cdb_src} !== {m_valid, m_tag, m_data, SW'(m_src)} || cdb_src !== 2'd0) begin
                errors++; $display("FAIL wrap_cdb[%0d] got=%b/%h/%h/%0d exp=%b/%h/%h/%0d", c, cdb_valid, cdb_tag, cdb_data, cdb_src, m_valid, m_tag, m_data, m_src);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [SW-1:0] order [5];
        // One grant to src 3 moves the pointer to 0 so the order starts at src 0.
        drive(1'b1, 1'b0, 4'b1000);
        tick();
        for (int i = 0; i < NS; i++) begin
            t_tag[i] = TW'(i + 1); t_data[i] = DW'(32'h1000 + i);
        end
        order[0] = 2'd0; order[1] = 2'd1; order[2] = 2'd2; order[3] = 2'd3; order[4] = 2'd0;
        for (int c = 0; c < 5; c++) begin
            drive(1'b1, 1'b0, 4'b1111);
            exp_r = model_ready();
            checks++;
            if (src_ready !== exp_r) begin
                errors++; $display("FAIL rr_ready[%0d] got=%b exp=%b", c, src_ready, exp_r);
            end
            tick();
            checks++;
            if ({cdb_valid, cdb_tag, cdb_data, cdb_src} !== {1'b1, TW'(order[c] + 1), DW'(32'h1000 + order[c]), order[c]}) begin
                errors++; $display("FAIL rr_cdb[%0d] got=%b/%h/%h/%0d exp=1/%h/%h/%0d", c, cdb_valid, cdb_tag, cdb_data, cdb_src, order[c] + 1, 32'h1000 + order[c], order[c]);
            end
        end
    endtask

    // Pointer is 1 here; flush must leave it there.
    task automatic test_flush();
        drive(1'b1, 1'b1, 4'b1111);
        checks++;
        if (src_ready !== 4'b0000) begin
            errors++; $display("FAIL flush_ready got=%b exp=0000", src_ready);
        end
        tick();
        checks++;
        if ({cdb_valid, cdb_tag, cdb_data, cdb_src} !== {1'b0, m_tag, m_data, SW'(m_src)}) begin
            errors++; $display("FAIL flush_cdb got=%b/%h/%h/%0d exp=0/%h/%h/%0d", cdb_valid, cdb_tag, cdb_data, cdb_src, m_tag, m_data, m_src);
        end
        drive(1'b1, 1'b0, 4'b1111);
        exp_r = model_ready();
        checks++;
        if (src_ready !== exp_r || src_ready !== 4'b0010) begin
            errors++; $display("FAIL flush_resume got=%b exp=%b", src_ready, exp_r);
        end
        tick();
        checks++;
        if ({cdb_valid, cdb_src} !== {1'b1, 2'd1}) begin
            errors++; $display("FAIL flush_resume_cdb got=%b/%0d exp=1/1", cdb_valid, cdb_src);
        end
    endtask

    task automatic test_reset_midstream();
        drive(1'b1, 1'b0, 4'b1111);
        tick();
        drive(1'b0, 1'b0, 4'b1111);
        checks++;
        if (src_ready !== 4'b0000) begin
            errors++; $display("FAIL midrst_ready got=%b exp=0000", src_ready);
        end
        tick();
        checks++;
        if (cdb_valid !== 1'b0) begin
            errors++; $display("FAIL midrst_cdb_valid got=%b exp=0", cdb_valid);
        end
        drive(1'b1, 1'b0, 4'b1111);
        checks++;
        if (src_ready !== 4'b0001) begin
            errors++; $display("FAIL midrst_ptr_ready got=%b exp=0001", src_ready);
        end
        tick();
        checks++;
        if ({cdb_valid, cdb_tag, cdb_data, cdb_src} !== {m_valid, m_tag, m_data, SW'(m_src)}) begin
            errors++; $display("FAIL midrst_cdb got=%b/%h/%h/%0d exp=%b/%h/%h/%0d", cdb_valid, cdb_tag, cdb_data, cdb_src, m_valid, m_tag, m_data, m_src);
        end
    endtask

    // Sources hold their payload until accepted; occasional flushes; fairness bound tracked.
    task automatic test_random();
        logic [NS-1:0] pending;
        int            wait_cnt [NS];
        logic          fl;
        pending = '0;
        for (int i = 0; i < NS; i++) wait_cnt[i] = 0;
        for (int c = 0; c < 400; c++) begin
            fl = ($urandom_range(0, 9) == 0);
            for (int i = 0; i < NS; i++) begin
                if (!pending[i] && $urandom_range(0, 2) != 0) begin
                    pending[i]  = 1'b1;
                    t_tag[i]    = TW'($urandom);
                    t_data[i]   = $urandom;
                    wait_cnt[i] = 0;
                end
            end
            drive(1'b1, fl, pending);
            exp_r = model_ready();
            checks++;
            if (src_ready !== exp_r) begin
                errors++; $display("FAIL rand_ready[%0d] got=%b exp=%b", c, src_ready, exp_r);
            end
            tick();
            checks++;
            if ({cdb_valid, cdb_tag, cdb_data, cdb_src} !== {m_valid, m_tag, m_data, SW'(m_src)}) begin
                errors++; $display("FAIL rand_cdb[%0d] got=%b/%h/%h/%0d exp=%b/%h/%h/%0d", c, cdb_valid, cdb_tag, cdb_data, cdb_src, m_valid, m_tag, m_data, m_src);
            end
            for (int i = 0; i < NS; i++) begin
                if (exp_r[i]) begin
                    checks++;
                    if (wait_cnt[i] > NS - 1) begin
                        errors++; $display("FAIL rand_fair src=%0d waited=%0d limit=%0d", i, wait_cnt[i], NS - 1);
                    end
                    pending[i] = 1'b0;
                end else if (pending[i] && !fl) begin
                    wait_cnt[i]++;
                end
            end
        end
    endtask

    initial begin
        reset_n = 1'b0; flush = 1'b0; src_valid = '0; src_tag = '0; src_data = '0;
        m_ptr = 0; m_valid = 1'b0; m_tag = '0; m_data = '0; m_src = 0;
        for (int i = 0; i < NS; i++) begin
            t_tag[i] = TW'(8 + i); t_data[i] = DW'(32'hA500 + i);
        end
        test_reset();
        test_single();
        test_wrap_sparse();
        test_back_to_back();
        test_flush();
        test_reset_midstream();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
